// File: rtl/looper_multi.sv
// looper_multi: loop-station effect (off / record / play / overdub).
// Each accepted sample runs one fixed 5-cycle SRAM sequence:
//   S_IDLE -> S_RD_REQ -> S_RD_LATCH -> S_MIX -> S_WRITE -> S_IDLE
// Optional feature macro: LOOPER_OVERDUB_EN. When it is defined, mode 3 is
// overdub, with a saturating read-mix-write. When it is undefined, mode 3 is
// treated as play and no overdub write hardware is built.
module looper_multi #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 352000,
    parameter int DEPTH     = 320000,
    parameter int LEVEL_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [1:0]         i_mode,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic [DATA_W-1:0]  i_sram_rdata,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic               o_sram_we_n,
    output logic [DATA_W-1:0]  o_sram_wdata,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    output logic               o_full,
    output logic [ADDR_W-1:0]  o_loop_len
);

    localparam int MIX_W = DATA_W + LEVEL_W + 2;
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_REC  = 2'd1;
    localparam logic [1:0] MODE_PLAY = 2'd2;
    localparam logic [1:0] MODE_ODUB = 2'd3;
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_LATCH = 3'd2,
        S_MIX      = 3'd3,
        S_WRITE    = 3'd4
    } state_t;

    state_t                     state_r, state_next_s;
    logic signed [DATA_W-1:0]   in_r, loop_r, data_r, mix_s, out_s;
    logic [LEVEL_W-1:0]         level_r;
    logic [1:0]                 mode_r, mode_in_s;
    logic [ADDR_W-1:0]          ptr_r, len_r, len_inc_s, ptr_inc_s, loop_addr_s;
    logic                       full_r, valid_r, ready_r;
    logic                       loop_mode_s, len_nz_s;
    logic [ADDR_W-1:0]          sram_addr_s;
    logic                       sram_we_n_s;
    logic [DATA_W-1:0]          sram_wdata_s;
    logic [LEVEL_W:0]           level_p1_s;
    logic signed [MIX_W-1:0]    in_ext_s, loop_ext_s, w_in_s, w_loop_s, mix_acc_s;

`ifdef LOOPER_OVERDUB_EN
    logic [DATA_W-1:0]          sum_s;

    // Two's-complement add clamped to the DATA_W signed range.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            if (s[DATA_W]) begin
                sat_add = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sat_add = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction
`endif

    // Effective mode: without overdub support, mode 3 collapses onto play.
    always_comb begin
`ifdef LOOPER_OVERDUB_EN
        mode_in_s = i_mode;
`else
        if (i_mode == MODE_ODUB) begin
            mode_in_s = MODE_PLAY;
        end else begin
            mode_in_s = i_mode;
        end
`endif
    end

    // Pointer arithmetic, loop address and mode qualifiers.
    always_comb begin
        len_inc_s   = len_r + ONE_A;
        ptr_inc_s   = ptr_r + ONE_A;
        loop_addr_s = ADDR_W'(BASE_ADDR) + ptr_r;
        loop_mode_s = (mode_r == MODE_PLAY) || (mode_r == MODE_ODUB);
        len_nz_s    = (len_r != '0);
    end

    // Weighted mix of live input and loop sample; the weights always sum to 2^LEVEL_W.
    always_comb begin
        level_p1_s = {1'b0, level_r} + {{LEVEL_W{1'b0}}, 1'b1};
        in_ext_s   = {{(MIX_W-DATA_W){in_r[DATA_W-1]}}, in_r};
        loop_ext_s = {{(MIX_W-DATA_W){loop_r[DATA_W-1]}}, loop_r};
        w_in_s     = {{(MIX_W-LEVEL_W){1'b0}}, ~level_r};
        w_loop_s   = {{(MIX_W-LEVEL_W-1){1'b0}}, level_p1_s};
        mix_acc_s  = (in_ext_s * w_in_s) + (loop_ext_s * w_loop_s);
        mix_s      = DATA_W'(mix_acc_s >>> LEVEL_W);
    end

    // Output sample selection: mix only when a loop exists to play against.
    always_comb begin
        if (loop_mode_s && len_nz_s) begin
            out_s = mix_s;
        end else begin
            out_s = in_r;
        end
    end

`ifdef LOOPER_OVERDUB_EN
    // Overdub write value: live input plus stored take, saturated.
    always_comb begin
        sum_s = sat_add(in_r, loop_r);
    end
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and combinational SRAM port drive.
    always_comb begin
        state_next_s = state_r;
        sram_addr_s  = '0;
        sram_we_n_s  = 1'b1;
        sram_wdata_s = '0;
        case (state_r)
            S_IDLE: begin
                if (i_valid) begin
                    state_next_s = S_RD_REQ;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RD_REQ: begin
                state_next_s = S_RD_LATCH;
                sram_addr_s  = loop_addr_s;
            end
            S_RD_LATCH: begin
                state_next_s = S_MIX;
                sram_addr_s  = loop_addr_s;
            end
            S_MIX: begin
                state_next_s = S_WRITE;
            end
            S_WRITE: begin
                state_next_s = S_IDLE;
                sram_addr_s  = loop_addr_s;
                if ((mode_r == MODE_REC) && !full_r) begin
                    sram_we_n_s  = 1'b0;
                    sram_wdata_s = in_r;
                end
`ifdef LOOPER_OVERDUB_EN
                else if ((mode_r == MODE_ODUB) && len_nz_s) begin
                    sram_we_n_s  = 1'b0;
                    sram_wdata_s = sum_s;
                end
`endif
                else begin
                    sram_we_n_s  = 1'b1;
                    sram_wdata_s = '0;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Sample capture, mode transitions, loop read latch, output register, pointer walk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_r    <= '0;
            loop_r  <= '0;
            data_r  <= '0;
            level_r <= '0;
            mode_r  <= MODE_OFF;
            ptr_r   <= '0;
            len_r   <= '0;
            full_r  <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (mode_in_s == MODE_OFF) begin
                        ptr_r <= '0;
                        len_r <= '0;
                    end
                    if (i_valid) begin
                        in_r    <= i_data;
                        level_r <= i_level;
                        mode_r  <= mode_in_s;
                        if ((mode_in_s == MODE_REC) && (mode_r != MODE_REC)) begin
                            ptr_r  <= '0;
                            len_r  <= '0;
                            full_r <= 1'b0;
                        end else if (((mode_in_s == MODE_PLAY) || (mode_in_s == MODE_ODUB)) &&
                                     ((mode_r == MODE_OFF) || (mode_r == MODE_REC))) begin
                            ptr_r <= '0;
                        end
                    end
                end
                S_RD_LATCH: begin
                    loop_r <= (loop_mode_s && len_nz_s) ? i_sram_rdata : '0;
                end
                S_MIX: begin
                    data_r <= out_s;
                end
                S_WRITE: begin
                    if ((mode_r == MODE_REC) && !full_r) begin
                        ptr_r <= ptr_inc_s;
                        len_r <= len_inc_s;
                        if (len_inc_s == ADDR_W'(DEPTH)) begin
                            full_r <= 1'b1;
                        end
                    end else if (loop_mode_s && len_nz_s) begin
                        ptr_r <= (ptr_r == (len_r - ONE_A)) ? '0 : ptr_inc_s;
                    end
                end
                default: begin
                end
            endcase
            valid_r <= (state_next_s == S_WRITE);
            ready_r <= (state_next_s == S_IDLE);
        end
    end

    assign o_ready      = ready_r;
    assign o_valid      = valid_r;
    assign o_data       = data_r;
    assign o_full       = full_r;
    assign o_loop_len   = len_r;
    assign o_sram_addr  = sram_addr_s;
    assign o_sram_we_n  = sram_we_n_s;
    assign o_sram_wdata = sram_wdata_s;

endmodule

// File: tb/tb_looper_multi.sv
// Directed bench for looper_multi: one default instance and one with DEPTH=3
// sharing the same stimulus, each with its own small SRAM model.
module tb_looper_multi;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [15:0] i_data = 16'sd0;
    logic [1:0]         i_mode = 2'd0;
    logic [2:0]         i_level = 3'd0;

    logic               a_ready, a_we_n, a_valid, a_full;
    logic [19:0]        a_addr, a_len;
    logic [15:0]        a_wdata, a_rdata;
    logic signed [15:0] a_data;
    logic               b_ready, b_we_n, b_valid, b_full;
    logic [19:0]        b_addr, b_len;
    logic [15:0]        b_wdata, b_rdata;
    logic signed [15:0] b_data;

    int vectors = 0;
    int miscompares = 0;

    // observations captured by drive_sample
    logic [3:0]         obs_vpat, obs_rpat;
    logic [19:0]        obs_raddr, obs_waddr;
    logic signed [15:0] obs_data, obs_b_data;
    logic               obs_we_n, obs_b_we_n;
    logic [15:0]        obs_wdata;

    logic [15:0] mem_a [0:15];
    logic [15:0] mem_b [0:15];
    logic [19:0] off_a, off_b;

    looper_multi dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(a_ready),
        .i_data(i_data), .i_mode(i_mode), .i_level(i_level), .i_sram_rdata(a_rdata),
        .o_sram_addr(a_addr), .o_sram_we_n(a_we_n), .o_sram_wdata(a_wdata),
        .o_data(a_data), .o_valid(a_valid), .o_full(a_full), .o_loop_len(a_len)
    );

    looper_multi #(.DEPTH(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(b_ready),
        .i_data(i_data), .i_mode(i_mode), .i_level(i_level), .i_sram_rdata(b_rdata),
        .o_sram_addr(b_addr), .o_sram_we_n(b_we_n), .o_sram_wdata(b_wdata),
        .o_data(b_data), .o_valid(b_valid), .o_full(b_full), .o_loop_len(b_len)
    );

    initial forever #5 clk = ~clk;

    // SRAM models: 16 words starting at the loop base address, combinational read.
    always_comb begin
        off_a   = a_addr - 20'd352000;
        off_b   = b_addr - 20'd352000;
        a_rdata = 16'd0;
        b_rdata = 16'd0;
        if (off_a < 20'd16) a_rdata = mem_a[off_a[3:0]];
        if (off_b < 20'd16) b_rdata = mem_b[off_b[3:0]];
    end

    always @(posedge clk) begin
        if (!a_we_n && off_a < 20'd16) mem_a[off_a[3:0]] <= a_wdata;
        if (!b_we_n && off_b < 20'd16) mem_b[off_b[3:0]] <= b_wdata;
    end

    // Called at posedge+1 in idle; returns at posedge+1 back in idle.
    task automatic drive_sample(input int d, input logic [1:0] m, input logic [2:0] lv);
        i_valid = 1'b1; i_data = 16'(d); i_mode = m; i_level = lv;
        @(posedge clk); #1;
        i_valid = 1'b0;
        obs_vpat = 4'd0; obs_rpat = 4'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            obs_vpat[k] = a_valid;
            obs_rpat[k] = a_ready;
            if (k == 0) obs_raddr = a_addr;
            if (k == 3) begin
                obs_data = a_data; obs_we_n = a_we_n; obs_wdata = a_wdata; obs_waddr = a_addr;
                obs_b_data = b_data; obs_b_we_n = b_we_n;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        i_valid = 1'b1; i_data = 16'sd77; i_mode = 2'd1; i_level = 3'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
                miscompares++; $display("FAIL rst_valid: got %b/%b, expected 0", a_valid, b_valid);
            end
        end
        vectors++; if (a_addr !== 20'd0) begin miscompares++; $display("FAIL rst_addr: got %0d, expected 0", a_addr); end
        vectors++; if (a_we_n !== 1'b1) begin miscompares++; $display("FAIL rst_we_n: got %b, expected 1", a_we_n); end
        vectors++; if (a_wdata !== 16'd0) begin miscompares++; $display("FAIL rst_wdata: got %0d, expected 0", a_wdata); end
        vectors++; if (a_data !== 16'sd0) begin miscompares++; $display("FAIL rst_data: got %0d, expected 0", a_data); end
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b, expected 1", a_ready); end
        vectors++; if (a_full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b, expected 0", a_full); end
        vectors++; if (a_len !== 20'd0) begin miscompares++; $display("FAIL rst_len: got %0d, expected 0", a_len); end
        i_valid = 1'b0; i_mode = 2'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
                miscompares++; $display("FAIL idle: got valid=%b ready=%b, expected 0/1", a_valid, a_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_record();
        int vals [4] = '{100, -200, 300, -400};
        for (int i = 0; i < 4; i++) begin
            drive_sample(vals[i], 2'd1, 3'd0);
            if (i == 0) begin
                vectors++; if (obs_vpat !== 4'b1000) begin miscompares++; $display("FAIL rec_vpat: got %b, expected 1000", obs_vpat); end
                vectors++; if (obs_rpat !== 4'b0000) begin miscompares++; $display("FAIL rec_rpat: got %b, expected 0000", obs_rpat); end
                vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rec_ready_back: got %b, expected 1", a_ready); end
            end
            vectors++; if (obs_we_n !== 1'b0) begin miscompares++; $display("FAIL rec_we_n[%0d]: got %b, expected 0", i, obs_we_n); end
            vectors++; if (obs_wdata !== 16'(vals[i])) begin miscompares++; $display("FAIL rec_wdata[%0d]: got %0d, expected %0d", i, $signed(obs_wdata), vals[i]); end
            vectors++; if (obs_waddr !== 20'(352000 + i)) begin miscompares++; $display("FAIL rec_waddr[%0d]: got %0d, expected %0d", i, obs_waddr, 352000 + i); end
            vectors++; if (obs_data !== 16'(vals[i])) begin miscompares++; $display("FAIL rec_data[%0d]: got %0d, expected %0d", i, obs_data, vals[i]); end
        end
        vectors++; if (a_len !== 20'd4) begin miscompares++; $display("FAIL rec_len: got %0d, expected 4", a_len); end
    endtask

    task automatic test_play_max();
        int vals [5] = '{100, -200, 300, -400, 100};
        for (int i = 0; i < 5; i++) begin
            drive_sample(0, 2'd2, 3'd7);
            vectors++; if (obs_data !== 16'(vals[i])) begin miscompares++; $display("FAIL play_max[%0d]: got %0d, expected %0d", i, obs_data, vals[i]); end
            vectors++; if (obs_raddr !== 20'(352000 + (i % 4))) begin miscompares++; $display("FAIL play_raddr[%0d]: got %0d, expected %0d", i, obs_raddr, 352000 + (i % 4)); end
            vectors++; if (obs_we_n !== 1'b1) begin miscompares++; $display("FAIL play_we_n[%0d]: got %b, expected 1", i, obs_we_n); end
        end
    endtask

    task automatic test_play_level();
        int ins [4] = '{800, -800, 801, -801};
        int lvs [4] = '{0, 3, 5, 5};
        int exp [4] = '{710, -360, 260, -141};
        drive_sample(80, 2'd1, 3'd0);
        vectors++; if (a_len !== 20'd1) begin miscompares++; $display("FAIL lvl_len: got %0d, expected 1", a_len); end
        for (int i = 0; i < 4; i++) begin
            drive_sample(ins[i], 2'd2, 3'(lvs[i]));
            vectors++; if (obs_data !== 16'(exp[i])) begin miscompares++; $display("FAIL play_level[%0d]: got %0d, expected %0d", i, obs_data, exp[i]); end
            if (i == 0) begin
                vectors++; if (obs_vpat !== 4'b1000) begin miscompares++; $display("FAIL play_vpat: got %b, expected 1000", obs_vpat); end
            end
        end
    endtask

    task automatic test_overdub();
`ifdef LOOPER_OVERDUB_EN
        int exp_d [3] = '{30000, 1000, 32767};
        int exp_w [3] = '{32767, 6000, 32767};
`else
        int exp_d [3] = '{30000, 1000, 30000};
`endif
        drive_sample(30000, 2'd1, 3'd0);
        drive_sample(1000, 2'd1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            drive_sample(5000, 2'd3, 3'd7);
            vectors++; if (obs_data !== 16'(exp_d[i])) begin miscompares++; $display("FAIL odub_data[%0d]: got %0d, expected %0d", i, obs_data, exp_d[i]); end
`ifdef LOOPER_OVERDUB_EN
            vectors++; if (obs_we_n !== 1'b0) begin miscompares++; $display("FAIL odub_we_n[%0d]: got %b, expected 0", i, obs_we_n); end
            vectors++; if (obs_wdata !== 16'(exp_w[i])) begin miscompares++; $display("FAIL odub_wdata[%0d]: got %0d, expected %0d", i, obs_wdata, exp_w[i]); end
`else
            vectors++; if (obs_we_n !== 1'b1 || obs_wdata !== 16'd0) begin miscompares++; $display("FAIL odub_nowrite[%0d]: got we_n=%b wdata=%0d, expected 1/0", i, obs_we_n, obs_wdata); end
`endif
        end
    endtask

    task automatic test_full();
        int vals [5] = '{11, 22, 33, 44, 55};
        for (int i = 0; i < 5; i++) begin
            drive_sample(vals[i], 2'd1, 3'd0);
            vectors++; if (obs_b_we_n !== (i >= 3)) begin miscompares++; $display("FAIL full_we_n[%0d]: got %b, expected %b", i, obs_b_we_n, (i >= 3)); end
            vectors++; if (obs_b_data !== 16'(vals[i])) begin miscompares++; $display("FAIL full_data[%0d]: got %0d, expected %0d", i, obs_b_data, vals[i]); end
            vectors++; if (b_full !== (i >= 2)) begin miscompares++; $display("FAIL full_flag[%0d]: got %b, expected %b", i, b_full, (i >= 2)); end
        end
        vectors++; if (b_len !== 20'd3) begin miscompares++; $display("FAIL full_len: got %0d, expected 3", b_len); end
        vectors++; if (a_len !== 20'd5 || a_full !== 1'b0) begin miscompares++; $display("FAIL deep_len: got %0d/%b, expected 5/0", a_len, a_full); end
    endtask

    task automatic test_mode0_drop();
        int vcount = 0;
        int wcount = 0;
        i_mode = 2'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (a_len !== 20'd0 || b_len !== 20'd0) begin miscompares++; $display("FAIL mode0_len: got %0d/%0d, expected 0/0", a_len, b_len); end
        drive_sample(1234, 2'd0, 3'd7);
        vectors++; if (obs_data !== 16'sd1234) begin miscompares++; $display("FAIL off_data: got %0d, expected 1234", obs_data); end
        vectors++; if (obs_we_n !== 1'b1) begin miscompares++; $display("FAIL off_we_n: got %b, expected 1", obs_we_n); end
        i_mode = 2'd1; i_data = 16'sd9; i_level = 3'd0; i_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) i_valid = 1'b0;
            @(negedge clk);
            if (a_valid) vcount++;
            if (!a_we_n) wcount++;
            @(posedge clk); #1;
        end
        vectors++; if (vcount != 1) begin miscompares++; $display("FAIL drop_valid_count: got %0d, expected 1", vcount); end
        vectors++; if (wcount != 1) begin miscompares++; $display("FAIL drop_write_count: got %0d, expected 1", wcount); end
        vectors++; if (a_len !== 20'd1) begin miscompares++; $display("FAIL drop_len: got %0d, expected 1", a_len); end
    endtask

    task automatic test_reset_mid();
        i_mode = 2'd2; i_data = 16'sd5; i_level = 3'd3; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (a_ready !== 1'b1 || a_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_hs: got ready=%b valid=%b, expected 1/0", a_ready, a_valid); end
        vectors++; if (a_addr !== 20'd0 || a_we_n !== 1'b1) begin miscompares++; $display("FAIL midrst_sram: got addr=%0d we_n=%b, expected 0/1", a_addr, a_we_n); end
        vectors++; if (a_len !== 20'd0 || a_data !== 16'sd0) begin miscompares++; $display("FAIL midrst_state: got len=%0d data=%0d, expected 0/0", a_len, a_data); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_novalid: got %b, expected 0", a_valid); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_record();
        test_play_max();
        test_play_level();
        test_overdub();
        test_full();
        test_mode0_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
